// File: rtl/fir_decim_avg_pkg.sv
// rtl/fir_decim_avg_pkg.sv - shared constants and helpers for the decimating averager
package fir_decim_avg_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int DECIM_LOG2_DEF = 2;
  localparam int FIFO_DEPTH     = 2;
  localparam int DROP_CNT_W     = 8;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fir_out_fifo2.sv
// rtl/fir_out_fifo2.sv - two-entry synchronous output FIFO with push/pop/full/empty
module fir_out_fifo2
  import fir_decim_avg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == 2'(FIFO_DEPTH));
  assign empty = (count_q == 2'd0);
  assign dout  = mem_q[rd_ptr_q];

  // A push while full is accepted only when the head leaves on the same edge.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fir_decim_avg.sv
// rtl/fir_decim_avg.sv - block-average decimator: sums D samples, outputs floor mean via FIFO
module fir_decim_avg
  import fir_decim_avg_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DECIM_LOG2 = DECIM_LOG2_DEF
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  In_valid,
  input  logic [DATA_W-1:0]     Din,
  input  logic                  Out_ready,
  input  logic                  Clr_ovr,
  output logic                  Out_valid,
  output logic [DATA_W-1:0]     Dout,
  output logic                  Overrun,
  output logic [DROP_CNT_W-1:0] Drop_cnt
);

  localparam int ACC_W = DATA_W + DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0] PHASE_LAST = '1;
  localparam logic [DECIM_LOG2-1:0] PHASE_ONE  = DECIM_LOG2'(1);

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DECIM_LOG2-1:0]    phase_q, phase_d;
  logic                     overrun_q, overrun_d;
  logic [DROP_CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic signed [ACC_W-1:0]  din_ext, sum, shifted;
  logic [DATA_W-1:0]        result;
  logic                     push, pop, drop;
  logic                     fifo_full, fifo_empty;

  assign din_ext = {{DECIM_LOG2{Din[DATA_W-1]}}, Din};
  assign sum     = acc_q + din_ext;
  assign shifted = sum >>> DECIM_LOG2;

  always_comb begin
    acc_d      = acc_q;
    phase_d    = phase_q;
    push       = 1'b0;
    result     = shifted[DATA_W-1:0];
    overrun_d  = overrun_q;
    drop_cnt_d = drop_cnt_q;
    if (In_valid) begin
      phase_d = phase_q + PHASE_ONE;
      if (phase_q == PHASE_LAST) begin
        acc_d = '0;
        push  = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
    pop  = Out_ready && !fifo_empty;
    drop = push && fifo_full && !pop;
    // A drop on the clearing edge still counts, so the flag never hides it.
    if (Clr_ovr) begin
      overrun_d  = drop;
      drop_cnt_d = drop ? DROP_CNT_W'(1) : '0;
    end else if (drop) begin
      overrun_d  = 1'b1;
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      acc_q      <= '0;
      phase_q    <= '0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fir_out_fifo2 #(
    .DATA_W (DATA_W)
  ) u_out_fifo (
    .clk   (Clk),
    .rst_n (Rst_n),
    .push  (push),
    .pop   (Out_ready),
    .din   (result),
    .dout  (Dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign Out_valid = !fifo_empty;
  assign Overrun   = overrun_q;
  assign Drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fir_decim_avg.sv
// tb/tb_fir_decim_avg.sv - directed vector bench for fir_decim_avg (D=4, 16-bit)
module tb_fir_decim_avg;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] din;
  logic               out_ready;
  logic               clr_ovr;
  logic               out_valid;
  logic signed [15:0] dout;
  logic               overrun;
  logic [7:0]         drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string              name;
    logic               iv;
    logic signed [15:0] d;
    logic               rdy;
    logic               clr;
    logic               ev;
    logic signed [15:0] ed;
    logic               eo;
    logic [7:0]         ec;
  } vec_t;

  vec_t vecs[$];

  fir_decim_avg dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .In_valid  (in_valid),
    .Din       (din),
    .Out_ready (out_ready),
    .Clr_ovr   (clr_ovr),
    .Out_valid (out_valid),
    .Dout      (dout),
    .Overrun   (overrun),
    .Drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic ev, input logic signed [15:0] ed,
                     input logic eo, input logic [7:0] ec);
    cmp({nm, ".valid"}, int'(out_valid), int'(ev));
    if (ev) cmp({nm, ".dout"}, int'(dout), int'(ed));
    cmp({nm, ".overrun"}, int'(overrun), int'(eo));
    cmp({nm, ".drop_cnt"}, int'(drop_cnt), int'(ec));
  endtask

  task automatic step(input logic iv, input logic signed [15:0] d,
                      input logic rdy, input logic clr);
    in_valid  = iv;
    din       = d;
    out_ready = rdy;
    clr_ovr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input logic iv, input int d, input logic rdy,
                     input logic clr, input logic ev, input int ed, input logic eo,
                     input int ec);
    vecs.push_back('{nm, iv, 16'(d), rdy, clr, ev, 16'(ed), eo, 8'(ec)});
  endtask

  initial begin
    rst_n = 1'b0;
    step(1'b0, 16'sd0, 1'b0, 1'b0);
    step(1'b1, 16'sd77, 1'b1, 1'b1);
    chk("reset", 1'b0, 16'sd0, 1'b0, 8'd0);
    cmp("reset.dout", int'(dout), 0);
    rst_n = 1'b1;

    add("pos1",  1, 1, 1, 0, 0, 0, 0, 0);
    add("pos2",  1, 2, 1, 0, 0, 0, 0, 0);
    add("pos3",  1, 3, 1, 0, 0, 0, 0, 0);
    add("pos4",  1, 4, 1, 0, 1, 2, 0, 0);
    add("posp",  0, 0, 1, 0, 0, 0, 0, 0);
    add("neg1",  1, -1, 1, 0, 0, 0, 0, 0);
    add("neg2",  1, -2, 1, 0, 0, 0, 0, 0);
    add("neg3",  1, -3, 1, 0, 0, 0, 0, 0);
    add("neg4",  1, -4, 1, 0, 1, -3, 0, 0);
    add("negp",  0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("max", 1, 32767, 1, 0, 0, 0, 0, 0);
    add("max4",  1, 32767, 1, 0, 1, 32767, 0, 0);
    add("maxp",  0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("min", 1, -32768, 1, 0, 0, 0, 0, 0);
    add("min4",  1, -32768, 1, 0, 1, -32768, 0, 0);
    add("minp",  0, 0, 1, 0, 0, 0, 0, 0);
    add("gap5",  1, 5, 1, 0, 0, 0, 0, 0);
    add("gapa",  0, 99, 1, 0, 0, 0, 0, 0);
    add("gap6",  1, 6, 1, 0, 0, 0, 0, 0);
    add("gapb",  0, 99, 1, 0, 0, 0, 0, 0);
    add("gap7",  1, 7, 1, 0, 0, 0, 0, 0);
    add("gapc",  0, 99, 1, 0, 0, 0, 0, 0);
    add("gap8",  1, 8, 1, 0, 1, 6, 0, 0);
    add("gapp",  0, 0, 1, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      chk(vecs[i].name, vecs[i].ev, vecs[i].ed, vecs[i].eo, vecs[i].ec);
    end

    // Overrun: two results held, the third dropped, then drained.
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 16'sd8, 1'b0, 1'b0);
      if (i == 4) chk("ovr.first", 1'b1, 16'sd8, 1'b0, 8'd0);
    end
    chk("ovr.drop", 1'b1, 16'sd8, 1'b1, 8'd1);
    step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("ovr.pop1", 1'b1, 16'sd8, 1'b1, 8'd1);
    step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("ovr.pop2", 1'b0, 16'sd0, 1'b1, 8'd1);
    step(1'b0, 16'sd0, 1'b0, 1'b1);
    chk("ovr.clr", 1'b0, 16'sd0, 1'b0, 8'd0);

    // Full FIFO, third result lands on a pop edge: no drop.
    for (int i = 0; i < 4; i++) step(1'b1, 16'sd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'sd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'sd3, 1'b0, 1'b0);
    chk("fullpop.full", 1'b1, 16'sd1, 1'b0, 8'd0);
    step(1'b1, 16'sd3, 1'b1, 1'b0);
    chk("fullpop.edge", 1'b1, 16'sd2, 1'b0, 8'd0);
    step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("fullpop.pop2", 1'b1, 16'sd3, 1'b0, 8'd0);
    step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("fullpop.empty", 1'b0, 16'sd0, 1'b0, 8'd0);

    // Reset with a buffered result and a half-summed group.
    for (int i = 0; i < 4; i++) step(1'b1, 16'sd9, 1'b0, 1'b0);
    chk("rst.buffered", 1'b1, 16'sd9, 1'b0, 8'd0);
    step(1'b1, 16'sd100, 1'b0, 1'b0);
    step(1'b1, 16'sd100, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 16'sd100, 1'b1, 1'b0);
    chk("rst.mid", 1'b0, 16'sd0, 1'b0, 8'd0);
    cmp("rst.mid.dout", int'(dout), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 16'sd4, 1'b1, 1'b0);
    chk("rst.partial", 1'b0, 16'sd0, 1'b0, 8'd0);
    step(1'b1, 16'sd4, 1'b1, 1'b0);
    chk("rst.fresh", 1'b1, 16'sd4, 1'b0, 8'd0);
    step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("rst.drain", 1'b0, 16'sd0, 1'b0, 8'd0);

    // Clear racing a drop, then drop-count saturation.
    for (int i = 0; i < 12; i++) step(1'b1, 16'sd7, 1'b0, 1'b0);
    chk("clr.pre", 1'b1, 16'sd7, 1'b1, 8'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'sd7, 1'b0, 1'b0);
    step(1'b1, 16'sd7, 1'b0, 1'b1);
    chk("clr.withdrop", 1'b1, 16'sd7, 1'b1, 8'd1);
    step(1'b0, 16'sd0, 1'b0, 1'b1);
    chk("clr.nodrop", 1'b1, 16'sd7, 1'b0, 8'd0);
    for (int i = 0; i < 256 * 4; i++) step(1'b1, 16'sd7, 1'b0, 1'b0);
    chk("sat.255", 1'b1, 16'sd7, 1'b1, 8'd255);
    for (int i = 0; i < 4; i++) step(1'b1, 16'sd7, 1'b0, 1'b0);
    chk("sat.hold", 1'b1, 16'sd7, 1'b1, 8'd255);
    step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("sat.pop1", 1'b1, 16'sd7, 1'b1, 8'd255);
    step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("sat.pop2", 1'b0, 16'sd0, 1'b1, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
